// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
// Turns single-word cache memory-port requests into single-beat AXI3
// transactions and returns the result through a one-cycle completion pulse.
// Only one transaction is outstanding at a time.
//
// Ports
//   clk, clrn                 clock (rising edge) / async active-low reset
//   c_a, c_din, c_strobe, c_rw  cache request (held until c_ready)
//   c_dout, c_ready, c_err    cache completion (c_err valid with c_ready)
//   ar*/r*                    AXI read address / read data channels
//   aw*/w*/b*                 AXI write address / data / response channels
module cache_axi_bridge #(
  parameter int         A_WIDTH = 32,
  parameter logic [3:0] AXI_ID  = 4'd1
) (
  input  logic               clk,
  input  logic               clrn,
  // cache side
  input  logic [A_WIDTH-1:0] c_a,
  input  logic [31:0]        c_din,
  input  logic               c_strobe,
  input  logic               c_rw,
  output logic [31:0]        c_dout,
  output logic               c_ready,
  output logic               c_err,
  // AXI read address
  output logic [3:0]         arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  // AXI read data
  input  logic [3:0]         rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  // AXI write address
  output logic [3:0]         awid,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  // AXI write data
  output logic [3:0]         wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  // AXI write response
  input  logic [3:0]         bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, DONE} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] a_q;
  logic [31:0]        din_q;
  logic               aw_done;
  logic               w_done;
  logic               aw_hs;
  logic               w_hs;

  // Single-beat word transfers only: burst fields are fixed.
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;
  assign wlast   = 1'b1;
  assign araddr  = a_q;
  assign awaddr  = a_q;
  assign wdata   = din_q;

  // IDs and rlast carry no information for a single-beat, single-ID master.
  logic unused;
  assign unused = ^{rid, rlast, bid};

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Direction is not kept in a register: it is fully encoded by the
  // RADDR/WADDR branch taken when the request is latched.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      a_q     <= '0;
      din_q   <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      c_dout  <= '0;
      c_ready <= 1'b0;
      c_err   <= 1'b0;
    end else begin
      // completion outputs live for the single DONE cycle only
      c_ready <= 1'b0;
      c_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (c_strobe) begin
            a_q   <= c_a;
            din_q <= c_din;
            if (c_rw) begin
              state   <= WADDR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rready  <= 1'b0;
            c_dout  <= rdata;
            c_err   <= |rresp;
            c_ready <= 1'b1;
            state   <= DONE;
          end
        end
        WADDR: begin
          // address and data channels retire independently, in any order
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            c_err   <= |bresp;
            c_ready <= 1'b1;
            state   <= DONE;
          end
        end
        // strobe seen here still belongs to the request just completed
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Testbench for cache_axi_bridge: directed scenarios followed by randomized
// transactions. A driver issues requests and pushes expected completions into
// a scoreboard; an AXI slave model replays per-transaction delays/responses
// and checks channel behaviour; a monitor pops the scoreboard on c_ready.
module tb_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] c_a, c_din, c_dout;
  logic        c_strobe, c_rw, c_ready, c_err;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  cache_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
    .clk(clk), .clrn(clrn),
    .c_a(c_a), .c_din(c_din), .c_strobe(c_strobe), .c_rw(c_rw),
    .c_dout(c_dout), .c_ready(c_ready), .c_err(c_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(4'd1), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(4'd1), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rw;
    bit [31:0] addr, din, rdata;
    bit [1:0]  resp;
    int        ar_dly, r_dly, aw_dly, w_dly, b_dly;
    bit        b2b;
  } txn_t;

  typedef struct {
    bit [31:0] dout;
    bit        err;
    int        rdy_cyc;
  } exp_t;

  txn_t      slq[$];
  exp_t      sb[$];
  int        vectors = 0;
  int        miscompares = 0;
  int        cyc = 0;
  bit [31:0] last_read = 0;
  bit        in_done = 0;
  bit        abort = 0;
  bit        prev_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Issue one request (called at a negedge) and wait for its completion.
  task automatic run_txn(input txn_t t);
    int   n;
    int   lat;
    exp_t e;
    c_a = t.addr; c_din = t.din; c_rw = t.rw; c_strobe = 1'b1;
    slq.push_back(t);
    if (!t.rw) begin
      lat = 3 + t.ar_dly + t.r_dly;
      e.dout = t.rdata;
      last_read = t.rdata;
    end else begin
      lat = 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
      e.dout = last_read;
    end
    e.err = (t.resp != 2'b00);
    // issued during DONE: one extra cycle before the bridge is back in IDLE
    e.rdy_cyc = cyc + lat + (in_done ? 1 : 0);
    sb.push_back(e);
    repeat (in_done ? 2 : 1) @(negedge clk);
    // request is latched; cache-side inputs must no longer matter
    c_a = $urandom; c_din = $urandom; c_rw = $urandom_range(0, 1);
    n = 0;
    while (!c_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!c_ready) begin
      miscompares++;
      $display("FAIL completion_timeout: got no c_ready expected c_ready within 400 cycles");
      finish_run();
    end
    if (t.b2b) begin
      in_done = 1'b1;
    end else begin
      in_done = 1'b0;
      c_strobe = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: completion scoreboard plus per-cycle channel rules.
  always @(negedge clk) begin
    exp_t e;
    if (clrn) begin
      if (arvalid && awvalid) chk("ar_aw_exclusive", 2'b11, 2'b00);
      if (c_ready) begin
        if (prev_ready) chk("c_ready_single_pulse", 1, 0);
        if (sb.size() == 0) begin
          chk("unexpected_c_ready", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("c_dout", c_dout, e.dout);
          chk("c_err", c_err, e.err);
          chk("latency_cycle", cyc, e.rdy_cyc);
        end
      end
    end
    prev_ready = c_ready;
  end

  // AXI slave model.
  task automatic serve();
    txn_t t;
    bit   have;
    int   k;
    bit   awh, wh, awh_n, wh_n;
    have = (slq.size() != 0);
    if (have) begin
      t = slq.pop_front();
    end else begin
      chk("unexpected_axi_txn", 1, 0);
      t = '{rw: awvalid, default: 0};
    end
    if (!t.rw) begin
      chk("read_direction", {arvalid, awvalid}, 2'b10);
      for (int i = 0; i <= t.ar_dly; i++) begin
        if (have) chk("araddr", araddr, t.addr);
        chk("arvalid_held", arvalid, 1);
        arready = (i == t.ar_dly);
        @(negedge clk);
      end
      arready = 1'b0;
      if (!abort) chk("arvalid_drop", arvalid, 0);
      repeat (t.r_dly) @(negedge clk);
      if (!abort) chk("rready", rready, 1);
      rvalid = 1'b1; rdata = t.rdata; rresp = t.resp;
      @(negedge clk);
      rvalid = 1'b0; rdata = $urandom; rresp = 2'(($urandom_range(0, 3)));
    end else begin
      chk("write_direction", {arvalid, awvalid, wvalid}, 3'b011);
      if (have) begin
        chk("awaddr", awaddr, t.addr);
        chk("wdata", wdata, t.din);
      end
      k = 0; awh = 0; wh = 0;
      while (!(awh && wh) && k < 300) begin
        chk("awvalid_state", awvalid, !awh);
        chk("wvalid_state", wvalid, !wh);
        awready = !awh && (k >= t.aw_dly);
        wready  = !wh && (k >= t.w_dly);
        awh_n = awh | (awready & awvalid);
        wh_n  = wh | (wready & wvalid);
        @(negedge clk);
        awh = awh_n; wh = wh_n;
        k++;
      end
      awready = 1'b0; wready = 1'b0;
      chk("aw_w_valids_dropped", {awvalid, wvalid}, 2'b00);
      repeat (t.b_dly) @(negedge clk);
      chk("bready", bready, 1);
      bvalid = 1'b1; bresp = t.resp;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'(($urandom_range(0, 3)));
    end
  endtask

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (clrn && (arvalid || awvalid)) serve();
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL global_watchdog: got timeout expected end of run");
    finish_run();
  end

  function automatic txn_t mk(input bit rw, input bit [31:0] a, input bit [31:0] d,
                              input bit [31:0] rd, input bit [1:0] rs,
                              input int ard, input int rdd, input int awd,
                              input int wd, input int bd, input bit b2b);
    txn_t t;
    t.rw = rw; t.addr = a; t.din = d; t.rdata = rd; t.resp = rs;
    t.ar_dly = ard; t.r_dly = rdd; t.aw_dly = awd; t.w_dly = wd; t.b_dly = bd;
    t.b2b = b2b;
    return t;
  endfunction

  initial begin
    txn_t t;
    clrn = 0; c_a = 0; c_din = 0; c_strobe = 0; c_rw = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {arvalid, awvalid, wvalid, rready, bready, c_ready, c_err}, 7'b0);
    chk("reset_c_dout", c_dout, 0);
    chk("const_fields", {arlen, awlen, arsize, awsize, arburst, awburst, wstrb, wlast},
        {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF, 1'b1});
    chk("axi_ids", {arid, awid, wid}, {4'd1, 4'd1, 4'd1});
    clrn = 1;

    // read with immediate arready / rvalid, issued right after reset release
    run_txn(mk(0, 32'h1FC0_0010, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
    // write: wready three cycles ahead of awready
    run_txn(mk(1, 32'h0000_0040, 32'h1234_5678, 0, 0, 0, 0, 3, 0, 0, 0));
    // write: address/data together, slow SLVERR response
    run_txn(mk(1, 32'h0000_0080, 32'hCAFE_F00D, 0, 2'b10, 0, 0, 0, 0, 5, 0));
    // back-to-back read then write with strobe held across DONE
    run_txn(mk(0, 32'h0000_1000, 0, 32'hA5A5_0001, 0, 0, 1, 0, 0, 0, 1));
    run_txn(mk(1, 32'h0000_2000, 32'h0BAD_CAFE, 0, 0, 0, 0, 1, 2, 1, 0));
    // read stalled in RADDR while c_a wanders
    run_txn(mk(0, 32'h0000_3000, 0, 32'h7777_8888, 2'b11, 4, 0, 0, 0, 0, 0));
    // minimum-latency write
    run_txn(mk(1, 32'h0000_4000, 32'h0F0F_0F0F, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset while waiting in RDATA
    abort = 1;
    t = mk(0, 32'h0000_5000, 0, 32'h5555_AAAA, 0, 0, 30, 0, 0, 0, 0);
    c_a = t.addr; c_rw = 0; c_strobe = 1;
    slq.push_back(t);
    repeat (2) @(negedge clk);
    chk("rdata_wait_rready", rready, 1);
    #1 clrn = 0;
    #1;
    chk("async_reset_outputs",
        {arvalid, awvalid, wvalid, rready, bready, c_ready, c_err}, 7'b0);
    chk("async_reset_c_dout", c_dout, 0);
    c_strobe = 0;
    last_read = 0;
    @(negedge clk);
    clrn = 1;
    repeat (35) @(negedge clk);
    abort = 0;
    // write first: c_dout must still read the post-reset value
    run_txn(mk(1, 32'h0000_6000, 32'h1111_2222, 0, 0, 0, 0, 1, 0, 0, 0));
    run_txn(mk(0, 32'h0000_7000, 0, 32'h3333_4444, 0, 1, 1, 0, 0, 0, 0));

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      t.rw     = $urandom_range(0, 1);
      t.addr   = $urandom;
      t.din    = $urandom;
      t.rdata  = $urandom;
      t.resp   = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      t.ar_dly = $urandom_range(0, 4);
      t.r_dly  = $urandom_range(0, 4);
      t.aw_dly = $urandom_range(0, 4);
      t.w_dly  = $urandom_range(0, 4);
      t.b_dly  = $urandom_range(0, 4);
      t.b2b    = (i != 149) && ($urandom_range(0, 3) == 0);
      run_txn(t);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("slave_queue_drained", slq.size(), 0);
    finish_run();
  end

endmodule
